// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT power-spectrum averager.
package fft_pkg;

    typedef enum logic {IDLE, ACCUM} pavg_state_t;

    function automatic int mag_w(int w);
        return 2 * w + 1;
    endfunction

    function automatic int acc_w(int w, int max_log2);
        return 2 * w + 1 + max_log2;
    endfunction

endpackage

// File: rtl/fft_power_avg_if.sv
// Stream bundle between the FFT core, the power averager and its consumer.
interface fft_power_avg_if import fft_pkg::*; #(
    parameter int W        = 16,
    parameter int NBINS    = 256,
    parameter int MAX_LOG2 = 4
);
    localparam int BW = $clog2(NBINS);
    localparam int NW = $clog2(MAX_LOG2 + 1);
    localparam int MW = mag_w(W);

    logic                in_valid;
    logic                in_sop;
    logic signed [W-1:0] fft_real;
    logic signed [W-1:0] fft_imag;
    logic [NW-1:0]       avg_log2;
    logic                clear;
    logic                out_valid;
    logic                out_sop;
    logic                out_eop;
    logic [BW-1:0]       out_bin;
    logic [MW-1:0]       out_power;
    logic                err_frame;

    modport master (
        output in_valid, in_sop, fft_real, fft_imag, avg_log2, clear,
        input  out_valid, out_sop, out_eop, out_bin, out_power, err_frame
    );

    modport slave (
        input  in_valid, in_sop, fft_real, fft_imag, avg_log2, clear,
        output out_valid, out_sop, out_eop, out_bin, out_power, err_frame
    );
endinterface

// File: rtl/mag_sq_pipe.sv
// Two-stage |x|^2: squares registered in the first stage, their exact sum in the second.
module mag_sq_pipe import fft_pkg::*; #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic signed [W-1:0] re,
    input  logic signed [W-1:0] im,
    output logic                out_valid,
    output logic [mag_w(W)-1:0] mag
);
    localparam int MW = mag_w(W);

    logic signed [2*W-1:0] re_x;
    logic signed [2*W-1:0] im_x;
    logic [2*W-1:0]        sq_re_q;
    logic [2*W-1:0]        sq_im_q;
    logic                  valid_q;

    // Widen before multiplying so (-2^(W-1))^2 keeps its full 2W-bit value.
    assign re_x = (2*W)'(re);
    assign im_x = (2*W)'(im);

    // NOTE: clocked state uses <= so every stage samples the previous stage's old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            out_valid <= 1'b0;
            sq_re_q   <= '0;
            sq_im_q   <= '0;
            mag       <= '0;
        end else begin
            valid_q   <= in_valid & ~flush;
            out_valid <= valid_q & ~flush;
            sq_re_q   <= re_x * re_x;
            sq_im_q   <= im_x * im_x;
            mag       <= MW'(sq_re_q) + MW'(sq_im_q);
        end
    end
endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module sdp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register; each bin is written before it is read back.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fft_power_avg.sv
// Per-bin power averager over 2^avg_log2 FFT frames, with frame-length checking.
module fft_power_avg import fft_pkg::*; #(
    parameter int W        = 16,
    parameter int NBINS    = 256,
    parameter int MAX_LOG2 = 4
) (
    input logic            clk,
    input logic            reset,
    fft_power_avg_if.slave bus
);
    localparam int BW = $clog2(NBINS);
    localparam int NW = $clog2(MAX_LOG2 + 1);
    localparam int FW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam int MW = mag_w(W);
    localparam int AW = acc_w(W, MAX_LOG2);

    typedef struct packed {
        logic [BW-1:0] bin;
        logic          first;
        logic          last;
        logic [NW-1:0] navg;
    } meta_t;

    pavg_state_t   state_q, state_d;
    logic [BW-1:0] bin_q, bin_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [NW-1:0] navg_q, navg_d;
    logic [FW-1:0] blk_frame;
    logic          take;
    logic          err_d;
    meta_t         meta_d, s1_q, s2_q;
    logic          s2_valid;
    logic [MW-1:0] s2_mag;
    logic [AW-1:0] rd_data;
    logic [AW-1:0] sum;

    // NOTE: every signal driven here gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        frame_d     = frame_q;
        navg_d      = navg_q;
        blk_frame   = frame_q;
        take        = 1'b0;
        err_d       = 1'b0;
        meta_d.bin  = bin_q;
        meta_d.navg = navg_q;

        if (bus.clear) begin
            state_d = IDLE;
            bin_d   = '0;
            frame_d = '0;
        end else if (bus.in_valid) begin
            if (bus.in_sop) begin
                // A sop mid-frame is a short frame: discard the block and restart on this sample.
                if (state_q == ACCUM && bin_q != '0) begin
                    err_d = 1'b1;
                end
                if (state_q == IDLE || bin_q != '0) begin
                    blk_frame = '0;
                end
                meta_d.navg = (blk_frame == '0) ? bus.avg_log2 : navg_q;
                meta_d.bin  = '0;
                take        = 1'b1;
                state_d     = ACCUM;
                bin_d       = BW'(1);
                frame_d     = blk_frame;
                navg_d      = meta_d.navg;
            end else if (state_q == ACCUM) begin
                if (bin_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    take  = 1'b1;
                    bin_d = bin_q + 1'b1;
                    if (bin_q == BW'(NBINS - 1)) begin
                        frame_d = (frame_q == FW'((1 << navg_q) - 1)) ? '0 : frame_q + 1'b1;
                    end
                end
            end
        end

        meta_d.first = (blk_frame == '0);
        meta_d.last  = (blk_frame == FW'((1 << meta_d.navg) - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            frame_q <= '0;
            navg_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            frame_q <= frame_d;
            navg_q  <= navg_d;
            s1_q    <= meta_d;
            s2_q    <= s1_q;
        end
    end

    mag_sq_pipe #(.W(W)) u_mag (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.clear),
        .in_valid  (take),
        .re        (bus.fft_real),
        .im        (bus.fft_imag),
        .out_valid (s2_valid),
        .mag       (s2_mag)
    );

    // Read issued one stage ahead so the stored sum lines up with the registered magnitude.
    sdp_ram #(.DEPTH(NBINS), .WIDTH(AW)) u_ram (
        .clk     (clk),
        .wr_en   (s2_valid & ~bus.clear),
        .wr_addr (s2_q.bin),
        .wr_data (sum),
        .rd_addr (s1_q.bin),
        .rd_data (rd_data)
    );

    assign sum = s2_q.first ? AW'(s2_mag) : rd_data + AW'(s2_mag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_bin   <= '0;
            bus.out_power <= '0;
            bus.err_frame <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.err_frame <= err_d;
            if (s2_valid && s2_q.last && !bus.clear) begin
                bus.out_valid <= 1'b1;
                bus.out_bin   <= s2_q.bin;
                bus.out_sop   <= (s2_q.bin == '0);
                bus.out_eop   <= (s2_q.bin == BW'(NBINS - 1));
                bus.out_power <= MW'(sum >> s2_q.navg);
            end
        end
    end
endmodule

// File: tb/tb_fft_power_avg.sv
// Bench for fft_power_avg: directed and random frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_power_avg;
    localparam int W        = 16;
    localparam int NBINS    = 8;
    localparam int MAX_LOG2 = 4;
    localparam int NW       = $clog2(MAX_LOG2 + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_power_avg_if #(.W(W), .NBINS(NBINS), .MAX_LOG2(MAX_LOG2)) bus ();

    fft_power_avg #(.W(W), .NBINS(NBINS), .MAX_LOG2(MAX_LOG2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int     bin;
        longint power;
        bit     sop;
        bit     eop;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc      = 0;
    int     checks   = 0;
    int     failures = 0;
    int     err_seen = 0;
    int     err_exp  = 0;
    int     gap_max  = 0;

    // Reference model: running per-bin sums, position in the frame, and frames done in the block.
    bit     m_active   = 1'b0;
    int     m_next_bin = 0;
    int     m_frame    = 0;
    int     m_navg     = 0;
    longint m_acc[NBINS];

    always @(posedge clk) cyc++;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_sample(bit sop, int re, int im);
        longint r = re;
        longint i = im;
        longint mag;
        int     b;
        int     last_f;
        mag = r * r + i * i;
        if (!m_active) begin
            if (!sop) return;
            m_active   = 1'b1;
            m_next_bin = 0;
            m_frame    = 0;
            m_navg     = int'(bus.avg_log2);
        end else if (sop && m_next_bin != 0) begin
            err_exp++;
            m_next_bin = 0;
            m_frame    = 0;
            m_navg     = int'(bus.avg_log2);
        end else if (!sop && m_next_bin == 0) begin
            err_exp++;
            return;
        end else if (sop && m_frame == 0) begin
            m_navg = int'(bus.avg_log2);
        end
        b      = m_next_bin;
        last_f = (1 << m_navg) - 1;
        if (m_frame == 0) m_acc[b] = mag;
        else              m_acc[b] += mag;
        if (m_frame == last_f)
            exp_q.push_back('{b, m_acc[b] >> m_navg, b == 0, b == NBINS - 1, cyc + 3});
        m_next_bin = (b + 1) % NBINS;
        if (b == NBINS - 1) m_frame = (m_frame == last_f) ? 0 : m_frame + 1;
    endtask

    task automatic drive(bit v, bit sop, int re, int im);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = v;
        bus.in_sop   = sop;
        bus.fft_real = W'(re);
        bus.fft_imag = W'(im);
        if (v) model_sample(sop, re, im);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic sample(bit sop, int re, int im);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        idle(g);
        drive(1'b1, sop, re, im);
    endtask

    task automatic frame_const(int re, int im);
        for (int k = 0; k < NBINS; k++) sample(k == 0, re, im);
    endtask

    function automatic int rnd();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic drain(string name);
        idle(6);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_err_count"}, err_seen, err_exp);
    endtask

    task automatic check_quiet(string name);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_out_sop"}, bus.out_sop, 0);
        check({name, "_out_eop"}, bus.out_eop, 0);
        check({name, "_out_bin"}, bus.out_bin, 0);
        check({name, "_out_power"}, bus.out_power, 0);
        check({name, "_err_frame"}, bus.err_frame, 0);
    endtask

    // Clear lands on the next edge; outputs due at or after that edge are suppressed.
    task automatic do_clear(bit with_sop);
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = with_sop;
        bus.in_sop   = with_sop;
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc + 1) void'(exp_q.pop_back());
        m_active = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.err_frame) err_seen++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got bin %0d power %0d, expected no output (cycle %0d)",
                             bus.out_bin, bus.out_power, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bin", bus.out_bin, e.bin);
                    check("out_power", bus.out_power, e.power);
                    check("out_sop", bus.out_sop, e.sop);
                    check("out_eop", bus.out_eop, e.eop);
                    check("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int a;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.fft_real = '0;
        bus.fft_imag = '0;
        bus.avg_log2 = '0;
        bus.clear    = 1'b0;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        // Pass-through: bin k carries re=k, im=-k, so power is 2k^2 with no averaging.
        gap_max = 0;
        bus.avg_log2 = NW'(0);
        for (int k = 0; k < NBINS; k++) sample(k == 0, k, -k);
        drain("pass_through");

        gap_max = 2;
        bus.avg_log2 = NW'(2);
        repeat (4) frame_const(3, 4);
        drain("avg4_const");

        bus.avg_log2 = NW'(1);
        frame_const(1, 0);
        frame_const(2, 0);
        drain("avg2_truncate");

        gap_max = 1;
        bus.avg_log2 = NW'(4);
        repeat (16) frame_const(-32768, -32768);
        drain("extreme_avg16");

        // Short frame: sop arrives at bin 5 of the third frame, restarting the block there.
        bus.avg_log2 = NW'(2);
        frame_const(5, 6);
        frame_const(5, 6);
        for (int k = 0; k < 5; k++) sample(k == 0, 1, 2);
        repeat (4) frame_const(2, 2);
        drain("short_frame");

        bus.avg_log2 = NW'(0);
        frame_const(2, 1);
        sample(1'b0, 7, 7);
        frame_const(1, 2);
        drain("long_frame");

        // Clear one cycle after bin 0 of the final frame, with a competing sop.
        gap_max = 0;
        bus.avg_log2 = NW'(1);
        frame_const(1, 1);
        sample(1'b1, 5, 5);
        do_clear(1'b1);
        for (int k = 1; k < NBINS; k++) sample(1'b0, 5, 5);
        frame_const(3, 0);
        frame_const(1, 0);
        drain("clear");

        bus.avg_log2 = NW'(0);
        for (int k = 0; k < 4; k++) sample(k == 0, 4, 4);
        @(negedge clk);
        #2;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_active = 1'b0;
        @(negedge clk);
        check_quiet("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        frame_const(1, 1);
        drain("after_reset");

        // Random blocks; avg_log2 is changed after the first frame and must not affect the block.
        gap_max = 2;
        for (int blk = 0; blk < 6; blk++) begin
            a = int'($urandom_range(MAX_LOG2, 0));
            bus.avg_log2 = NW'(a);
            for (int f = 0; f < (1 << a); f++) begin
                for (int k = 0; k < NBINS; k++) sample(k == 0, rnd(), rnd());
                if (f == 0) bus.avg_log2 = NW'($urandom_range(MAX_LOG2, 0));
            end
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
